// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage and its stack pointer unit.
package memory_stage_pkg;

    localparam int ADDR_W_DEF  = 11;
    localparam int SP_INIT_DEF = 'h7FF;

    // Number of memory cycles an operation occupies.
    localparam logic [1:0] LEN_SINGLE   = 2'd1;
    localparam logic [1:0] LEN_CALL_RET = 2'd2;
    localparam logic [1:0] LEN_INT_RTI  = 2'd3;

    typedef enum logic [1:0] {
        ADDR_ALU = 2'b00,
        ADDR_SP  = 2'b01,
        ADDR_RD2 = 2'b10,
        ADDR_VEC = 2'b11
    } addr_sel_e;

    typedef enum logic [1:0] {
        WSRC_RD1      = 2'b00,
        WSRC_PC       = 2'b01,
        WSRC_FLAGS_PC = 2'b10,
        WSRC_RSVD     = 2'b11
    } wsrc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_W2   = 2'b01,
        ST_W3   = 2'b10
    } mem_state_e;

    // Length of the current operation; reserved wsrc behaves as a plain one-word push.
    function automatic logic [1:0] stack_op_len(input logic push, input logic pop,
                                                 input wsrc_sel_e wsrc,
                                                 input logic pc_mem, input logic pc_int);
        logic [1:0] len;
        len = LEN_SINGLE;
        if (push) begin
            if (wsrc == WSRC_PC)            len = LEN_CALL_RET;
            else if (wsrc == WSRC_FLAGS_PC) len = LEN_INT_RTI;
        end else if (pop) begin
            if (pc_int)      len = LEN_INT_RTI;
            else if (pc_mem) len = LEN_CALL_RET;
        end
        return len;
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register; a signed delta in -3..+3 is committed once per stack operation.
module stack_pointer_unit #(
    parameter int                ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_i,
    input  logic [2:0]        delta_i,
    output logic [ADDR_W-1:0] sp_o
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    // Sign-extend the delta; arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        sp_d = sp_q;
        if (commit_i) sp_d = sp_q + {{(ADDR_W-3){delta_i[2]}}, delta_i};
    end

    // SP register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) sp_q <= SP_INIT;
        else        sp_q <= sp_d;
    end

    assign sp_o = sp_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory access, stack pointer, multi-word stack
// sequencing with upstream stall, and the MEM/WB buffer.
// Handshake: while stall is high the EX/MEM inputs must be held stable; the
// operation completes in the first cycle where stall is low, at whose edge the
// WB buffer and SP update.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ex_alu_result,
    input  logic [15:0]       ex_read_data1,
    input  logic [15:0]       ex_read_data2,
    input  logic [15:0]       ex_ldm_value,
    input  logic [15:0]       ex_inport_value,
    input  logic [31:0]       ex_pc_plus_one,
    input  logic [2:0]        ex_flags,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_push,
    input  logic              ex_mem_pop,
    input  logic [1:0]        ex_addr_sel,
    input  logic [1:0]        ex_wsrc_sel,
    input  logic              ex_pc_choose_memory,
    input  logic              ex_pc_choose_interrupt,
    input  logic              ex_reg_write,
    input  logic [2:0]        ex_reg_write_address,
    input  logic [1:0]        ex_wb_sel,
    input  logic              ex_outport_enable,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [15:0]       dmem_rdata,
    output logic              stall,
    output logic              wb_reg_write,
    output logic [2:0]        wb_reg_write_address,
    output logic [1:0]        wb_wb_sel,
    output logic              wb_outport_enable,
    output logic [15:0]       wb_alu_result,
    output logic [15:0]       wb_mem_data,
    output logic [15:0]       wb_ldm_value,
    output logic [15:0]       wb_inport_value,
    output logic [31:0]       pc_from_memory,
    output logic              pc_from_memory_valid,
    output logic [2:0]        conditions_from_memory_pop,
    output logic [ADDR_W-1:0] sp_out,
    output mem_state_e        dbg_state_o
);

    mem_state_e        state_q, state_d;
    logic [1:0]        step;
    logic [1:0]        step_next;
    logic [1:0]        op_len;
    logic              last_cycle;
    logic              push_op, pop_op, stack_nop;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] step_ext;
    logic [ADDR_W-1:0] base_addr;
    logic              we_raw, re_raw;
    logic              sp_commit;
    logic [2:0]        sp_delta;
    logic [15:0]       pop_hi_q, pop_lo_q;
    logic              unused_ok;

    assign unused_ok = ^{ex_read_data2[15:ADDR_W]};

    assign stack_nop = ex_mem_push & ex_mem_pop;
    assign push_op   = ex_mem_push & ~ex_mem_pop;
    assign pop_op    = ex_mem_pop & ~ex_mem_push;
    assign op_len    = stack_op_len(push_op, pop_op, wsrc_sel_e'(ex_wsrc_sel),
                                    ex_pc_choose_memory, ex_pc_choose_interrupt);

    // Word index within a multi-word op, derived from the FSM state.
    always_comb begin
        step = 2'd0;
        case (state_q)
            ST_W2:   step = 2'd1;
            ST_W3:   step = 2'd2;
            default: step = 2'd0;
        endcase
    end

    assign step_next  = step + 2'd1;
    assign last_cycle = (step_next >= op_len);
    assign step_ext   = {{(ADDR_W-2){1'b0}}, step};

    // Next-state: advance while words remain, otherwise return to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        if (!last_cycle) state_d = (state_q == ST_IDLE) ? ST_W2 : ST_W3;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Address and write-data selection; stack ops address relative to the un-updated SP.
    always_comb begin
        base_addr = '0;
        case (addr_sel_e'(ex_addr_sel))
            ADDR_ALU: base_addr = ex_alu_result[ADDR_W-1:0];
            ADDR_SP:  base_addr = sp;
            ADDR_RD2: base_addr = ex_read_data2[ADDR_W-1:0];
            default:  base_addr = '0;
        endcase
        if (push_op)     dmem_addr = sp - step_ext;
        else if (pop_op) dmem_addr = sp + step_ext + {{(ADDR_W-1){1'b0}}, 1'b1};
        else             dmem_addr = base_addr;

        dmem_wdata = ex_read_data1;
        if (push_op) begin
            case (wsrc_sel_e'(ex_wsrc_sel))
                WSRC_PC:
                    dmem_wdata = (step == 2'd0) ? ex_pc_plus_one[15:0] : ex_pc_plus_one[31:16];
                WSRC_FLAGS_PC: begin
                    if (step == 2'd0)      dmem_wdata = {13'b0, ex_flags};
                    else if (step == 2'd1) dmem_wdata = ex_pc_plus_one[15:0];
                    else                   dmem_wdata = ex_pc_plus_one[31:16];
                end
                default: dmem_wdata = ex_read_data1;
            endcase
        end
    end

    // Memory strobes: write beats read, vector address is read-only, push+pop is a NOP.
    always_comb begin
        we_raw = push_op |
                 (ex_mem_write & ~pop_op & ~stack_nop & (addr_sel_e'(ex_addr_sel) != ADDR_VEC));
        re_raw = ~we_raw & ~stack_nop & (pop_op | ex_mem_read);
        dmem_we = reset & we_raw;
        dmem_re = reset & re_raw;
        stall   = reset & ~last_cycle;
    end

    // SP moves once, by the full op length, on the final cycle.
    always_comb begin
        sp_commit = last_cycle & (push_op | pop_op);
        sp_delta  = push_op ? (3'd0 - {1'b0, op_len}) : {1'b0, op_len};
    end

    stack_pointer_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk      (clk),
        .reset    (reset),
        .commit_i (sp_commit),
        .delta_i  (sp_delta),
        .sp_o     (sp)
    );

    // Capture the early words of a multi-word pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_hi_q <= '0;
            pop_lo_q <= '0;
        end else if (pop_op) begin
            if (step == 2'd0) pop_hi_q <= dmem_rdata;
            if (step == 2'd1) pop_lo_q <= dmem_rdata;
        end
    end

    // Popped PC/flags with a one-cycle valid pulse after RET/RTI completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_from_memory             <= '0;
            pc_from_memory_valid       <= 1'b0;
            conditions_from_memory_pop <= '0;
        end else begin
            pc_from_memory_valid <= 1'b0;
            if (last_cycle && pop_op && op_len != LEN_SINGLE) begin
                pc_from_memory_valid <= 1'b1;
                if (op_len == LEN_CALL_RET) begin
                    pc_from_memory <= {pop_hi_q, dmem_rdata};
                end else begin
                    pc_from_memory             <= {pop_hi_q, pop_lo_q};
                    conditions_from_memory_pop <= dmem_rdata[2:0];
                end
            end
        end
    end

    // MEM/WB buffer: loads on the final cycle, bubbles reg_write otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_reg_write         <= 1'b0;
            wb_reg_write_address <= '0;
            wb_wb_sel            <= '0;
            wb_outport_enable    <= 1'b0;
            wb_alu_result        <= '0;
            wb_mem_data          <= '0;
            wb_ldm_value         <= '0;
            wb_inport_value      <= '0;
        end else if (last_cycle) begin
            wb_reg_write         <= ex_reg_write;
            wb_reg_write_address <= ex_reg_write_address;
            wb_wb_sel            <= ex_wb_sel;
            wb_outport_enable    <= ex_outport_enable;
            wb_alu_result        <= ex_alu_result;
            wb_mem_data          <= dmem_rdata;
            wb_ldm_value         <= ex_ldm_value;
            wb_inport_value      <= ex_inport_value;
        end else begin
            wb_reg_write         <= 1'b0;
        end
    end

    assign sp_out      = sp;
    assign dbg_state_o = state_q;

endmodule
